// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - shared widths, opcode mnemonics and issue record for the ALU issue stage
package alu_issue_stage_pkg;

  localparam int ISSUE_W   = 8;
  localparam int ISSUE_OPS = 4;
  localparam int ISSUE_A   = 3;

  typedef enum logic [ISSUE_OPS-1:0] {
    ADD = 4'd1,
    SUB = 4'd2,
    AND = 4'd3,
    OR  = 4'd4,
    XOR = 4'd5,
    SHL = 4'd6,
    SHR = 4'd7
  } op_mne;

  // All-zero opcode; this is what the ALU sees out of reset.
  localparam op_mne NOP = op_mne'(4'd0);

  typedef struct packed {
    op_mne              op;
    logic [ISSUE_W-1:0] a;
    logic [ISSUE_W-1:0] b;
    logic               sc;
  } issue_t;

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// rtl/alu_issue_stage_reg_file.sv - 2**A x W register file, two async read ports with write-back bypass
module alu_issue_stage_reg_file
  import alu_issue_stage_pkg::*;
#(
  parameter int W = ISSUE_W,
  parameter int A = ISSUE_A
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         wb_en,
  input  logic [A-1:0] wb_addr,
  input  logic [W-1:0] wb_data,
  input  logic [A-1:0] rd_addr_a,
  input  logic [A-1:0] rd_addr_b,
  output logic [W-1:0] rd_data_a,
  output logic [W-1:0] rd_data_b
);

  logic [W-1:0] mem_q [2**A];

  // Storage: reset clears every entry, otherwise one write per cycle from write-back.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 2**A; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wb_en) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  // A same-cycle write to the address being read is forwarded so the reader sees the new value.
  assign rd_data_a = (wb_en && (wb_addr == rd_addr_a)) ? wb_data : mem_q[rd_addr_a];
  assign rd_data_b = (wb_en && (wb_addr == rd_addr_b)) ? wb_data : mem_q[rd_addr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand-issue stage feeding the ALU through a valid/ready output register
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int W   = ISSUE_W,
  parameter int Ops = ISSUE_OPS,
  parameter int A   = ISSUE_A
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Ops-1:0] in_op,
  input  logic [A-1:0]   in_ra,
  input  logic [A-1:0]   in_rb,
  input  logic           in_use_imm,
  input  logic [W-1:0]   in_imm,
  input  logic           in_sc,
  input  logic           flush,
  input  logic           wb_en,
  input  logic [A-1:0]   wb_addr,
  input  logic [W-1:0]   wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   InputA,
  output logic [W-1:0]   InputB,
  output logic [Ops-1:0] OP,
  output logic           SC_in
);

  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b;
  issue_t       issue_d;
  issue_t       issue_q;
  logic         valid_q;
  logic         accept;

  alu_issue_stage_reg_file #(.W(W), .A(A)) u_rf (
    .Clk       (Clk),
    .Reset     (Reset),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rd_addr_a (in_ra),
    .rd_addr_b (in_rb),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b)
  );

  // Slot is free when empty or when the consumer takes the held entry this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand selection for the incoming instruction; immediate replaces register B.
  always_comb begin
    issue_d    = '0;
    issue_d.op = op_mne'(in_op);
    issue_d.a  = rd_a;
    issue_d.b  = in_use_imm ? in_imm : rd_b;
    issue_d.sc = in_sc;
  end

  // Output register: flush beats accept; on drain only the valid bit drops, data is kept.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      issue_q <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      issue_q <= issue_d;
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign InputA    = issue_q.a;
  assign InputB    = issue_q.b;
  assign OP        = issue_q.op;
  assign SC_in     = issue_q.sc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for the ALU issue stage
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_ra;
  logic [2:0] in_rb;
  logic       in_use_imm;
  logic [7:0] in_imm;
  logic       in_sc;
  logic       flush;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic [3:0] OP;
  logic       SC_in;

  int errors = 0;
  int checks = 0;
  logic [20:0] exp_q[$];

  alu_issue_stage dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .in_sc      (in_sc),
    .flush      (flush),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .InputA     (InputA),
    .InputB     (InputB),
    .OP         (OP),
    .SC_in      (SC_in)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] data);
    wb_en   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    step();
    wb_en   = 1'b0;
  endtask

  task automatic drive(input op_mne op, input logic [2:0] ra, input logic [2:0] rb,
                       input logic use_imm, input logic [7:0] imm, input logic sc);
    in_valid   = 1'b1;
    in_op      = op;
    in_ra      = ra;
    in_rb      = rb;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_sc      = sc;
  endtask

  // Drive one instruction for one cycle, recording the hand-computed result it must produce.
  task automatic issue(input op_mne op, input logic [2:0] ra, input logic [2:0] rb,
                       input logic use_imm, input logic [7:0] imm, input logic sc,
                       input logic [7:0] ea, input logic [7:0] eb);
    drive(op, ra, rb, use_imm, imm, sc);
    exp_q.push_back({op, ea, eb, sc});
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got op=%0h a=%0h b=%0h sc=%0b expected none", OP, InputA, InputB, SC_in);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        chk("issue_out", {OP, InputA, InputB, SC_in}, {11'd0, e});
      end
    end
  end

  initial begin
    Reset = 1'b1; in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0;
    in_use_imm = 1'b0; in_imm = '0; in_sc = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    step(); step();
    chk("reset_valid", out_valid, 0);
    chk("reset_ops", {OP, InputA, InputB, SC_in}, 0);
    Reset = 1'b0;

    // Reset mid-stream with a valid instruction held
    wr(3'd1, 8'h5A);
    drive(ADD, 3'd1, 3'd0, 1'b0, 8'h00, 1'b1);
    step();
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_a", InputA, 8'h5A);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_ops", {OP, InputA, InputB, SC_in}, 0);
    out_ready = 1'b1;
    issue(ADD, 3'd1, 3'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    step();

    // Back-to-back issue at full throughput
    wr(3'd2, 8'h03);
    wr(3'd3, 8'h04);
    issue(ADD, 3'd2, 3'd3, 1'b0, 8'h00, 1'b0, 8'h03, 8'h04);
    chk("b2b_valid_1", out_valid, 1);
    issue(SUB, 3'd3, 3'd2, 1'b0, 8'h00, 1'b1, 8'h04, 8'h03);
    chk("b2b_valid_2", out_valid, 1);
    step();
    chk("drain_valid", out_valid, 0);

    // Same-cycle write-back bypass on A, then plain read of the written register
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'h7E;
    issue(OR, 3'd5, 3'd0, 1'b0, 8'h00, 1'b0, 8'h7E, 8'h00);
    wb_en = 1'b0;
    issue(XOR, 3'd5, 3'd5, 1'b0, 8'h00, 1'b0, 8'h7E, 8'h7E);
    step();

    // Stall: held operands survive a write to their source register
    wr(3'd1, 8'h22);
    out_ready = 1'b0;
    issue(AND, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 8'h22, 8'h03);
    drive(SUB, 3'd3, 3'd3, 1'b0, 8'h00, 1'b0);
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_ops", {OP, InputA, InputB}, {AND, 8'h22, 8'h03});
      step();
      wb_en = 1'b0;
    end
    out_ready = 1'b1;
    exp_q.push_back({SUB, 8'h04, 8'h04, 1'b0});
    step();
    in_valid = 1'b0;
    step();
    issue(ADD, 3'd1, 3'd1, 1'b0, 8'h00, 1'b0, 8'hFF, 8'hFF);
    step();

    // Flush beats accept; the same-edge write-back still lands
    drive(ADD, 3'd2, 3'd3, 1'b0, 8'h00, 1'b0);
    flush = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h11;
    chk("flush_in_ready", in_ready, 1);
    step();
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    chk("flush_valid", out_valid, 0);
    issue(ADD, 3'd4, 3'd4, 1'b0, 8'h00, 1'b0, 8'h11, 8'h11);
    step();

    // Immediate replaces register B
    wr(3'd6, 8'h99);
    issue(AND, 3'd6, 3'd6, 1'b1, 8'h0F, 1'b1, 8'h99, 8'h0F);
    step();
    step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
